// File: rtl/key_debounce_cancel.sv
`default_nettype none
// ============================================================================
// key_debounce_cancel
// Synchronizes and debounces the cancel-buy button. Produces a clean level,
// press/release pulses, a long-press flag and a saturating bounce counter.
// Revision: 1.0
// ============================================================================
module key_debounce_cancel #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int HOLD_CYCLES     = 100000000,
  parameter bit KEY_ACTIVE_LOW  = 1'b1
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       key_raw,
  output logic       key_level,
  output logic       key_press_pulse,
  output logic       key_release_pulse,
  output logic       key_hold,
  output logic [7:0] bounce_cnt
);

  localparam int CNT_W  = $clog2(DEBOUNCE_CYCLES);
  localparam int HCNT_W = $clog2(HOLD_CYCLES);
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [HCNT_W-1:0] HCNT_LAST = HCNT_W'(HOLD_CYCLES - 1);

  generate
    if (DEBOUNCE_CYCLES < 2 || HOLD_CYCLES < 2) begin : g_param_check
      $error("key_debounce_cancel: DEBOUNCE_CYCLES and HOLD_CYCLES must be >= 2");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic                s1_q, s2_q;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [HCNT_W-1:0]   hcnt_q, hcnt_d;
  logic                level_q, level_d;
  logic                press_q, press_d;
  logic                release_q, release_d;
  logic                hold_q, hold_d;
  logic [7:0]          bounce_q, bounce_d;
  logic [7:0]          bounce_sat;
  logic                pressed_s;

  assign pressed_s  = s2_q ^ KEY_ACTIVE_LOW;
  assign bounce_sat = (bounce_q == 8'hFF) ? bounce_q : bounce_q + 8'd1;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_q      <= KEY_ACTIVE_LOW;
      s2_q      <= KEY_ACTIVE_LOW;
      state_q   <= IDLE;
      cnt_q     <= '0;
      hcnt_q    <= '0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      hold_q    <= 1'b0;
      bounce_q  <= 8'd0;
    end else begin
      s1_q      <= key_raw;
      s2_q      <= s1_q;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      hcnt_q    <= hcnt_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
      hold_q    <= hold_d;
      bounce_q  <= bounce_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hcnt_d    = hcnt_q;
    level_d   = level_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    hold_d    = hold_q;
    bounce_d  = bounce_q;
    case (state_q)
      IDLE: begin
        if (pressed_s) begin
          state_d = PRESS_WAIT;
          cnt_d   = '0;
        end
      end
      PRESS_WAIT: begin
        if (!pressed_s) begin
          state_d  = IDLE;
          cnt_d    = '0;
          bounce_d = bounce_sat;
        end else if (cnt_q == CNT_LAST) begin
          state_d = PRESSED;
          level_d = 1'b1;
          press_d = 1'b1;
          hcnt_d  = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      PRESSED: begin
        if (!pressed_s) begin
          state_d = RELEASE_WAIT;
          cnt_d   = '0;
        end else if (hcnt_q == HCNT_LAST) begin
          hold_d = 1'b1;
        end else begin
          hcnt_d = hcnt_q + 1'b1;
        end
      end
      RELEASE_WAIT: begin
        // A bounce back to pressed keeps the accumulated hold time.
        if (pressed_s) begin
          state_d  = PRESSED;
          cnt_d    = '0;
          bounce_d = bounce_sat;
        end else if (cnt_q == CNT_LAST) begin
          state_d   = IDLE;
          level_d   = 1'b0;
          hold_d    = 1'b0;
          hcnt_d    = '0;
          release_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign key_level         = level_q;
  assign key_press_pulse   = press_q;
  assign key_release_pulse = release_q;
  assign key_hold          = hold_q;
  assign bounce_cnt        = bounce_q;

endmodule
`default_nettype wire

// File: tb/tb_key_debounce_cancel.sv
`default_nettype none
// Bench for key_debounce_cancel: an active-low and an active-high instance fed
// complementary raw inputs, checked against a run-length reference model.
module tb_key_debounce_cancel;

  localparam int D = 8;
  localparam int H = 32;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       key_raw = 1'b1;
  logic       key_raw_ah;
  logic       lvl_al, pp_al, rp_al, hold_al;
  logic [7:0] bc_al;
  logic       lvl_ah, pp_ah, rp_ah, hold_ah;
  logic [7:0] bc_ah;

  int total = 0;
  int bad   = 0;

  assign key_raw_ah = ~key_raw;

  always #5 clk = ~clk;

  key_debounce_cancel #(.DEBOUNCE_CYCLES(D), .HOLD_CYCLES(H), .KEY_ACTIVE_LOW(1'b1)) dut_al (
    .clk(clk), .reset_n(reset_n), .key_raw(key_raw),
    .key_level(lvl_al), .key_press_pulse(pp_al), .key_release_pulse(rp_al),
    .key_hold(hold_al), .bounce_cnt(bc_al)
  );

  key_debounce_cancel #(.DEBOUNCE_CYCLES(D), .HOLD_CYCLES(H), .KEY_ACTIVE_LOW(1'b0)) dut_ah (
    .clk(clk), .reset_n(reset_n), .key_raw(key_raw_ah),
    .key_level(lvl_ah), .key_press_pulse(pp_ah), .key_release_pulse(rp_ah),
    .key_hold(hold_ah), .bounce_cnt(bc_ah)
  );

  // Reference: the accepted level flips once the synchronized pressed sense has
  // disagreed with it for D+1 consecutive edges; an aborted run is a bounce.
  bit m_s1, m_s2, m_p, m_lvl, m_pp, m_rp, m_hold;
  int m_run, m_hc, m_bc;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_s1 = 1'b0; m_s2 = 1'b0; m_lvl = 1'b0; m_pp = 1'b0; m_rp = 1'b0;
      m_hold = 1'b0; m_run = 0; m_hc = 0; m_bc = 0;
    end else begin
      m_p  = m_s2;
      m_pp = 1'b0;
      m_rp = 1'b0;
      if (m_p != m_lvl) begin
        m_run = m_run + 1;
        if (m_run == D + 1) begin
          m_lvl = m_p;
          m_run = 0;
          m_hc  = 0;
          if (m_p) m_pp = 1'b1;
          else begin
            m_rp   = 1'b1;
            m_hold = 1'b0;
          end
        end
      end else if (m_run > 0) begin
        m_run = 0;
        if (m_bc < 255) m_bc = m_bc + 1;
      end else if (m_lvl) begin
        if (m_hc < H) m_hc = m_hc + 1;
        if (m_hc >= H) m_hold = 1'b1;
      end
      m_s2 = m_s1;
      m_s1 = ~key_raw;
    end
  end

  task automatic cmp(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    cmp("al.level",   lvl_al,  m_lvl);
    cmp("al.press",   pp_al,   m_pp);
    cmp("al.release", rp_al,   m_rp);
    cmp("al.hold",    hold_al, m_hold);
    cmp("al.bounce",  bc_al,   m_bc);
    cmp("ah.level",   lvl_ah,  m_lvl);
    cmp("ah.press",   pp_ah,   m_pp);
    cmp("ah.release", rp_ah,   m_rp);
    cmp("ah.hold",    hold_ah, m_hold);
    cmp("ah.bounce",  bc_ah,   m_bc);
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    // Reset state
    step(3);
    cmp("rst.level", lvl_al, 0);
    cmp("rst.press", pp_al, 0);
    cmp("rst.hold", hold_al, 0);
    cmp("rst.bounce", bc_al, 0);
    reset_n = 1'b1;
    step(3);

    // Clean press: level rises on the 10th edge after E0
    key_raw = 1'b0;
    step(10);
    cmp("p1.level_early", lvl_al, 0);
    step(1);
    cmp("p1.level", lvl_al, 1);
    cmp("p1.press", pp_al, 1);
    cmp("p1.bounce", bc_al, 0);
    cmp("p1.ah_level", lvl_ah, 1);
    step(1);
    cmp("p1.press_end", pp_al, 0);
    step(38);

    // Release with two 3-cycle glitches
    key_raw = 1'b1; step(3); key_raw = 1'b0; step(3);
    key_raw = 1'b1; step(3); key_raw = 1'b0; step(5);
    cmp("p3.level_glitch", lvl_al, 1);
    cmp("p3.bounce_glitch", bc_al, 2);
    key_raw = 1'b1;
    step(10);
    cmp("p3.level_early", lvl_al, 1);
    cmp("p3.hold_early", hold_al, 1);
    step(1);
    cmp("p3.level", lvl_al, 0);
    cmp("p3.release", rp_al, 1);
    cmp("p3.hold_clr", hold_al, 0);
    cmp("p3.bounce", bc_al, 2);
    step(1);
    cmp("p3.release_end", rp_al, 0);
    step(4);

    // Three 4-cycle press glitches
    repeat (3) begin
      key_raw = 1'b0; step(4);
      key_raw = 1'b1; step(4);
    end
    step(4);
    cmp("p2.level", lvl_al, 0);
    cmp("p2.bounce", bc_al, 5);

    // Long press: hold rises 32 edges after level
    key_raw = 1'b0;
    step(11);
    cmp("p4.level", lvl_al, 1);
    step(31);
    cmp("p4.hold_early", hold_al, 0);
    step(1);
    cmp("p4.hold", hold_al, 1);
    step(17);
    key_raw = 1'b1;
    step(10);
    cmp("p4.hold_before_rel", hold_al, 1);
    step(1);
    cmp("p4.level_fall", lvl_al, 0);
    cmp("p4.hold_fall", hold_al, 0);
    step(3);

    // Reset mid-debounce with the key held
    key_raw = 1'b0;
    step(5);
    reset_n = 1'b0;
    #1;
    cmp("p5.rst_level", lvl_al, 0);
    cmp("p5.rst_bounce", bc_al, 0);
    cmp("p5.rst_bounce_ah", bc_ah, 0);
    step(2);
    cmp("p5.rst_hold", hold_al, 0);
    reset_n = 1'b1;
    step(10);
    cmp("p5.level_early", lvl_al, 0);
    step(1);
    cmp("p5.level", lvl_al, 1);
    cmp("p5.press", pp_al, 1);
    cmp("p5.ah_press", pp_ah, 1);
    step(5);
    key_raw = 1'b1;
    step(14);
    cmp("p5.level_end", lvl_al, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
